logic_unit_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit: successor to the fixed 4-bit NOT block, generalised to WIDTH bits and eight selectable operations. Operands and opcode enter through a valid/ready handshake and pass through two register stages with full backpressure. Results leave through a matching valid/ready output, and a counter tracks completed operations. It sits in the BinaryLogic datapath alongside the other arithmetic/logic units.

---
 rtl/logic_unit_pkg.sv | 34 +++
 rtl/logic_unit_if.sv | 41 ++++
 rtl/logic_unit_stage.sv | 43 ++++
 rtl/logic_unit_pipe.sv | 89 ++++++++
 tb/tb_logic_unit_pipe.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_unit_pkg.sv
// Shared opcode type and the bitwise op function for the pipelined logic unit.
package logic_unit_pkg;

  // Widest operand the op function handles; callers zero-extend and truncate.
  localparam int unsigned MaxWidth = 64;

  typedef enum logic [2:0] {
    OpAnd  = 3'd0,
    OpOr   = 3'd1,
    OpXor  = 3'd2,
    OpNot  = 3'd3,
    OpNand = 3'd4,
    OpNor  = 3'd5,
    OpXnor = 3'd6,
    OpPass = 3'd7
  } op_e;

  function automatic logic [MaxWidth-1:0] apply_op(op_e op, logic [MaxWidth-1:0] a,
                                                   logic [MaxWidth-1:0] b);
    logic [MaxWidth-1:0] res;
    case (op)
      OpAnd:   res = a & b;
      OpOr:    res = a | b;
      OpXor:   res = a ^ b;
      OpNot:   res = ~a;
      OpNand:  res = ~(a & b);
      OpNor:   res = ~(a | b);
      OpXnor:  res = ~(a ^ b);
      default: res = a;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/logic_unit_if.sv
// Handshake bundle for the logic unit; flag signals exist only with LOGIC_UNIT_FLAGS_EN.
interface logic_unit_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) ();
  import logic_unit_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  op_e              op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] op_count;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic             flag_zero;
  logic             flag_ones;
  logic             flag_parity;

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, op_count, flag_zero, flag_ones, flag_parity
  );
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, op_count, flag_zero, flag_ones, flag_parity
  );
`else
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, op_count
  );
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, op_count
  );
`endif

endinterface

// File: rtl/logic_unit_stage.sv
// Generic valid/ready register slice; data only updates when a beat is actually taken.
module logic_unit_stage #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    in_ready_o = !valid_q || out_ready_i;
    valid_d    = valid_q;
    data_d     = data_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        data_d = in_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit logic unit: two register slices with the op function between them.
// Define LOGIC_UNIT_FLAGS_EN to add registered zero/ones/parity flags on the result.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  logic_unit_if.slave bus
);

  localparam int unsigned S1W = 3 + 2 * WIDTH;
`ifdef LOGIC_UNIT_FLAGS_EN
  localparam int unsigned S2W = WIDTH + 3;
`else
  localparam int unsigned S2W = WIDTH;
`endif

  logic             s1_valid;
  logic             s2_ready;
  logic [S1W-1:0]   s1_data;
  logic [S2W-1:0]   s2_in;
  logic [S2W-1:0]   s2_data;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] op_res;
  op_e              s1_op;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic_unit_stage #(.DATA_W(S1W)) u_s1 (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   ({bus.op, bus.b, bus.a}),
    .out_valid_o (s1_valid),
    .out_ready_i (s2_ready),
    .out_data_o  (s1_data)
  );

  always_comb begin
    s1_a   = s1_data[WIDTH-1:0];
    s1_b   = s1_data[2*WIDTH-1:WIDTH];
    s1_op  = op_e'(s1_data[S1W-1 -: 3]);
    op_res = WIDTH'(apply_op(s1_op, MaxWidth'(s1_a), MaxWidth'(s1_b)));
`ifdef LOGIC_UNIT_FLAGS_EN
    s2_in  = {^op_res, &op_res, ~|op_res, op_res};
`else
    s2_in  = op_res;
`endif
  end

  logic_unit_stage #(.DATA_W(S2W)) u_s2 (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (s1_valid),
    .in_ready_o  (s2_ready),
    .in_data_i   (s2_in),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (s2_data)
  );

  always_comb begin
    op_count_d = op_count_q;
    if (bus.out_valid && bus.out_ready) begin
      op_count_d = op_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= '0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign bus.result   = s2_data[WIDTH-1:0];
  assign bus.op_count = op_count_q;
`ifdef LOGIC_UNIT_FLAGS_EN
  assign bus.flag_zero   = s2_data[WIDTH];
  assign bus.flag_ones   = s2_data[WIDTH+1];
  assign bus.flag_parity = s2_data[WIDTH+2];
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench: a 4-bit unit for directed tests, an 8-bit unit with a 3-bit counter
// for random stalls, counter wrap, reset-in-flight and (with LOGIC_UNIT_FLAGS_EN) flags.
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_unit_if #(.WIDTH(4), .CNT_W(16)) bus4 ();
  logic_unit_if #(.WIDTH(8), .CNT_W(3))  bus8 ();

  logic_unit_pipe #(.WIDTH(4), .CNT_W(16)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  logic_unit_pipe #(.WIDTH(8), .CNT_W(3))  u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

  int errors = 0;
  int checks = 0;
  int cnt4   = 0;
  int cnt8   = 0;

  // Truth table per opcode, indexed by {a_bit, b_bit}.
  logic [3:0] tt [8];

  function automatic logic [7:0] model(int op, logic [7:0] a, logic [7:0] b);
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) r[i] = tt[op][{a[i], b[i]}];
    return r;
  endfunction

  task automatic idle();
    bus4.in_valid = 0; bus4.a = '0; bus4.b = '0; bus4.op = OpAnd; bus4.out_ready = 1;
    bus8.in_valid = 0; bus8.a = '0; bus8.b = '0; bus8.op = OpAnd; bus8.out_ready = 1;
  endtask

  task automatic do_reset(int n);
    rst = 1;
    repeat (n) @(posedge clk);
    #1 rst = 0;
    cnt4 = 0;
    cnt8 = 0;
  endtask

  task automatic test_reset();
    idle();
    do_reset(2);
    @(negedge clk);
    checks++; if (bus4.out_valid !== 1'b0)
      begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus4.out_valid); end
    checks++; if (bus4.result !== 4'h0)
      begin errors++; $display("FAIL reset_result: got %h expected 0", bus4.result); end
    checks++; if (bus4.op_count !== 16'h0)
      begin errors++; $display("FAIL reset_op_count: got %h expected 0", bus4.op_count); end
    checks++; if (bus4.in_ready !== 1'b1)
      begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus4.in_ready); end
    checks++; if (bus8.op_count !== 3'h0)
      begin errors++; $display("FAIL reset_op_count8: got %h expected 0", bus8.op_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_all_ops();
    logic [3:0] exp_r [8];
    exp_r[0] = 4'b0001; exp_r[1] = 4'b1101; exp_r[2] = 4'b1100; exp_r[3] = 4'b0110;
    exp_r[4] = 4'b1110; exp_r[5] = 4'b0010; exp_r[6] = 4'b0011; exp_r[7] = 4'b1001;
    bus4.out_ready = 1; bus4.a = 4'b1001; bus4.b = 4'b0101;
    for (int c = 0; c < 10; c++) begin
      bus4.in_valid = (c < 8);
      bus4.op = op_e'(3'(c));
      @(negedge clk);
      if (c < 8) begin
        checks++; if (bus4.in_ready !== 1'b1)
          begin errors++; $display("FAIL ops_in_ready c=%0d: got %b expected 1", c, bus4.in_ready); end
      end
      if (c < 2) begin
        checks++; if (bus4.out_valid !== 1'b0)
          begin errors++; $display("FAIL ops_early_valid c=%0d: got %b expected 0", c, bus4.out_valid); end
      end else begin
        checks++; if (bus4.out_valid !== 1'b1 || bus4.result !== exp_r[c-2]) begin
          errors++;
          $display("FAIL ops_result op=%0d: got valid=%b result=%b expected valid=1 result=%b",
                   c - 2, bus4.out_valid, bus4.result, exp_r[c-2]);
        end
        if (bus4.out_valid && bus4.out_ready) cnt4++;
      end
      @(posedge clk); #1;
    end
    bus4.in_valid = 0;
    @(negedge clk);
    checks++; if (bus4.op_count !== 16'd8)
      begin errors++; $display("FAIL ops_count: got %0d expected 8", bus4.op_count); end
    checks++; if (bus4.out_valid !== 1'b0)
      begin errors++; $display("FAIL ops_drained: got %b expected 0", bus4.out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    op_e bo [3] = '{OpAnd, OpOr, OpXor};
    logic [3:0] got [$];
    logic [3:0] exp0;
    int k = 0;
    bus4.a = 4'b0011; bus4.b = 4'b0110;
    exp0 = 4'(model(int'(OpAnd), 8'h03, 8'h06));
    for (int c = 0; c < 12; c++) begin
      bus4.out_ready = (c >= 4);
      bus4.in_valid  = (k < 3);
      if (k < 3) bus4.op = bo[k];
      @(negedge clk);
      if (c == 1) begin
        checks++; if (bus4.in_ready !== 1'b1)
          begin errors++; $display("FAIL bp_second_accept: got %b expected 1", bus4.in_ready); end
      end
      if (c == 2 || c == 3) begin
        checks++; if (bus4.in_ready !== 1'b0)
          begin errors++; $display("FAIL bp_in_ready c=%0d: got %b expected 0", c, bus4.in_ready); end
        checks++; if (bus4.out_valid !== 1'b1 || bus4.result !== exp0) begin
          errors++;
          $display("FAIL bp_hold c=%0d: got valid=%b result=%b expected valid=1 result=%b",
                   c, bus4.out_valid, bus4.result, exp0);
        end
      end
      if (c == 3) begin
        checks++; if (k !== 2)
          begin errors++; $display("FAIL bp_accepted: got %0d expected 2", k); end
      end
      if (c == 4) begin
        checks++; if (bus4.in_ready !== 1'b1)
          begin errors++; $display("FAIL bp_full_accept: got %b expected 1", bus4.in_ready); end
      end
      if (bus4.in_valid && bus4.in_ready) k++;
      if (bus4.out_valid && bus4.out_ready) begin got.push_back(bus4.result); cnt4++; end
      @(posedge clk); #1;
    end
    checks++; if (got.size() !== 3)
      begin errors++; $display("FAIL bp_out_count: got %0d expected 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      logic [3:0] e;
      e = 4'(model(int'(bo[i]), 8'h03, 8'h06));
      checks++; if (got[i] !== e)
        begin errors++; $display("FAIL bp_order beat=%0d: got %b expected %b", i, got[i], e); end
    end
    @(negedge clk);
    checks++; if (bus4.op_count !== 16'(cnt4))
      begin errors++; $display("FAIL bp_count: got %0d expected %0d", bus4.op_count, cnt4); end
    @(posedge clk); #1;
  endtask

  task automatic test_random_stall();
    logic [7:0] q [$];
    logic [7:0] held_r = '0;
    logic [7:0] e;
    logic held_v = 1'b0;
    for (int c = 0; c < 1006; c++) begin
      if (c < 1000) begin
        bus8.in_valid  = 1'($urandom_range(0, 1));
        bus8.a         = 8'($urandom);
        bus8.b         = 8'($urandom);
        bus8.op        = op_e'(3'($urandom_range(0, 7)));
        bus8.out_ready = 1'($urandom_range(0, 1));
      end else begin
        bus8.in_valid  = 0;
        bus8.out_ready = 1;
      end
      @(negedge clk);
      if (held_v) begin
        checks++; if (bus8.out_valid !== 1'b1 || bus8.result !== held_r) begin
          errors++;
          $display("FAIL rnd_stall_hold c=%0d: got valid=%b result=%h expected valid=1 result=%h",
                   c, bus8.out_valid, bus8.result, held_r);
        end
      end
      held_v = bus8.out_valid && !bus8.out_ready;
      held_r = bus8.result;
      if (bus8.out_valid && bus8.out_ready) begin
        cnt8++;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_extra_beat c=%0d: got %h expected no beat", c, bus8.result);
        end else begin
          e = q.pop_front();
          if (bus8.result !== e)
            begin errors++; $display("FAIL rnd_result c=%0d: got %h expected %h", c, bus8.result, e); end
        end
      end
      if (bus8.in_valid && bus8.in_ready)
        q.push_back(model(int'(bus8.op), bus8.a, bus8.b));
      @(posedge clk); #1;
    end
    checks++; if (q.size() !== 0)
      begin errors++; $display("FAIL rnd_lost: got %0d pending expected 0", q.size()); end
    @(negedge clk);
    checks++; if (bus8.op_count !== 3'(cnt8))
      begin errors++; $display("FAIL rnd_count: got %0d expected %0d", bus8.op_count, 3'(cnt8)); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap_and_reset();
    int n = 0;
    idle();
    do_reset(1);
    bus8.a = 8'h3C; bus8.b = 8'h0F; bus8.op = OpXor;
    for (int c = 0; c < 12; c++) begin
      bus8.in_valid = (c < 9);
      @(negedge clk);
      if (bus8.out_valid && bus8.out_ready) n++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (n !== 9)
      begin errors++; $display("FAIL wrap_transfers: got %0d expected 9", n); end
    checks++; if (bus8.op_count !== 3'd1)
      begin errors++; $display("FAIL wrap_count: got %0d expected 1", bus8.op_count); end
    @(posedge clk); #1;
    // Fill both stages under stall, then reset while a transfer would otherwise happen.
    n = 0;
    bus8.out_ready = 0; bus8.in_valid = 1; bus8.a = 8'h5A; bus8.op = OpPass;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (!bus8.in_ready) break;
      n++;
      @(posedge clk); #1;
    end
    checks++; if (n !== 2 || bus8.in_ready !== 1'b0 || bus8.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_fill: got accepts=%0d in_ready=%b out_valid=%b expected 2 0 1",
               n, bus8.in_ready, bus8.out_valid);
    end
    rst = 1; bus8.out_ready = 1;
    @(posedge clk); #1;
    rst = 0; bus8.in_valid = 0;
    cnt4 = 0; cnt8 = 0;
    @(negedge clk);
    checks++; if (bus8.out_valid !== 1'b0 || bus8.op_count !== 3'd0 || bus8.result !== 8'h00) begin
      errors++;
      $display("FAIL rst_flush: got valid=%b count=%0d result=%h expected 0 0 00",
               bus8.out_valid, bus8.op_count, bus8.result);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (bus8.out_valid !== 1'b0)
        begin errors++; $display("FAIL rst_ghost c=%0d: got valid=%b expected 0", c, bus8.out_valid); end
    end
    @(posedge clk); #1;
  endtask

`ifdef LOGIC_UNIT_FLAGS_EN
  task automatic test_flags();
    op_e        fo [3] = '{OpXor, OpNot, OpPass};
    logic [7:0] fa [3] = '{8'hA5, 8'h00, 8'h01};
    logic [2:0] fe [3] = '{3'b001, 3'b010, 3'b100};  // {parity, ones, zero}
    logic found;
    bus8.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      bus8.in_valid = 1; bus8.op = fo[i]; bus8.a = fa[i]; bus8.b = fa[i];
      @(posedge clk); #1;
      bus8.in_valid = 0;
      found = 0;
      for (int w = 0; w < 5 && !found; w++) begin
        @(negedge clk);
        if (bus8.out_valid) found = 1;
        else begin @(posedge clk); #1; end
      end
      checks++;
      if (!found) begin
        errors++; $display("FAIL flags_timeout vec=%0d: got no out_valid expected a beat", i);
      end else if ({bus8.flag_parity, bus8.flag_ones, bus8.flag_zero} !== fe[i]) begin
        errors++;
        $display("FAIL flags vec=%0d: got {par,ones,zero}=%b expected %b", i,
                 {bus8.flag_parity, bus8.flag_ones, bus8.flag_zero}, fe[i]);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0011;
    tt[4] = 4'b0111; tt[5] = 4'b0001; tt[6] = 4'b1001; tt[7] = 4'b1100;
    rst = 1;
    idle();
    test_reset();
    test_all_ops();
    test_backpressure();
    test_random_stall();
    test_wrap_and_reset();
`ifdef LOGIC_UNIT_FLAGS_EN
    test_flags();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
